// File: rtl/fp_mac_acc.sv
// Streamed floating-point multiply-accumulate: multiplies sample x coefficient,
// sums a frame in a wide internal format, and rounds the total on the last tap.
module fp_mac_acc #(
  parameter int EXP_W   = 5,
  parameter int MAN_W   = 10,
  parameter int GUARD_W = 3,
  parameter int CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] in_a,
  input  logic [EXP_W+MAN_W:0] in_b,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] out_y,
  output logic [CNT_W-1:0]     out_taps,
  output logic                 out_ovf,
  output logic                 out_uf
);

  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int PW    = 2 * (MAN_W + 1);
  localparam int ACC_W = PW + GUARD_W;
  localparam int EXT   = ACC_W + 1;
  localparam int PEW   = EXP_W + 2;
  localparam int AEW   = EXP_W + 4;
  localparam int LZW   = $clog2(EXT + 1);
  localparam int BIAS  = (1 << (EXP_W - 1)) - 1;
  localparam int EMAX  = (1 << EXP_W) - 1;

  function automatic logic [LZW-1:0] lzc(input logic [EXT-1:0] v);
    lzc = LZW'(EXT);
    for (int i = 0; i < EXT; i++) begin
      if (v[i]) lzc = LZW'(EXT - 1 - i);
    end
  endfunction

  // Valid/ready: a transfer happens on a rising clk edge where valid && ready.
  // Once out_valid rises, out_y/out_taps/flags hold until out_ready, and every
  // pipeline register stalls with them, so in_ready simply mirrors that enable.
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  logic                  sa, sb;
  logic [EXP_W-1:0]      ea, eb;
  logic [MAN_W-1:0]      fa, fb;
  logic [MAN_W:0]        ma, mb;
  logic signed [PEW-1:0] uea, ueb;

  assign {sa, ea, fa} = in_a;
  assign {sb, eb, fb} = in_b;
  assign ma  = {|ea, fa};
  assign mb  = {|eb, fb};
  assign uea = (ea == '0) ? PEW'(1 - BIAS) : $signed(PEW'(ea)) - PEW'(BIAS);
  assign ueb = (eb == '0) ? PEW'(1 - BIAS) : $signed(PEW'(eb)) - PEW'(BIAS);

  logic                  s1_valid, s1_sign, s1_zero, s1_last;
  logic [PW-1:0]         s1_man;
  logic signed [PEW-1:0] s1_exp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_zero  <= 1'b0;
      s1_last  <= 1'b0;
      s1_man   <= '0;
      s1_exp   <= '0;
    end else if (adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign <= sa ^ sb;
        s1_man  <= PW'(ma) * PW'(mb);
        s1_exp  <= uea + ueb;
        s1_zero <= (ma == '0) || (mb == '0);
        s1_last <= in_last;
      end
    end
  end

  // Accumulator magnitude has one integer bit; its LSB is a sticky bit that
  // takes part in add/subtract so rounding sees bits shifted out during alignment.
  logic                  acc_nz, acc_sign;
  logic signed [AEW-1:0] acc_exp;
  logic [EXT-1:0]        acc_mag;
  logic [CNT_W-1:0]      acc_cnt;

  logic                  s2_valid, s2_nz, s2_sign;
  logic signed [AEW-1:0] s2_exp;
  logic [EXT-1:0]        s2_mag;
  logic [CNT_W-1:0]      s2_taps;

  logic                  x_sign, big_s, sm_s, r_s, sum_nz, sum_s;
  logic signed [AEW-1:0] p_exp, x_exp, big_e, sm_e, sum_e;
  logic [EXT-1:0]        p_mag, x_mag, big_m, sm_m, al, sum_m;
  logic signed [AEW:0]   ediff;
  logic [LZW-1:0]        shamt, lz;
  logic [2*EXT-1:0]      sh_full;
  logic [EXT:0]          r;
  logic [CNT_W-1:0]      cnt_inc;

  assign p_exp   = AEW'(s1_exp) + AEW'(1);
  assign p_mag   = {s1_man, {(GUARD_W + 1){1'b0}}};
  assign cnt_inc = (&acc_cnt) ? acc_cnt : acc_cnt + CNT_W'(1);

  always_comb begin
    x_sign = acc_nz ? acc_sign : s1_sign;
    x_exp  = acc_nz ? acc_exp : p_exp;
    x_mag  = acc_nz ? acc_mag : '0;
    if (x_exp >= p_exp) begin
      big_s = x_sign;  big_e = x_exp; big_m = x_mag;
      sm_s  = s1_sign; sm_e  = p_exp; sm_m  = p_mag;
    end else begin
      big_s = s1_sign; big_e = p_exp; big_m = p_mag;
      sm_s  = x_sign;  sm_e  = x_exp; sm_m  = x_mag;
    end
    ediff   = (AEW+1)'(big_e) - (AEW+1)'(sm_e);
    shamt   = (ediff >= (AEW+1)'(EXT)) ? LZW'(EXT) : ediff[LZW-1:0];
    sh_full = {sm_m, {EXT{1'b0}}} >> shamt;
    al      = sh_full[2*EXT-1:EXT] | {{(EXT-1){1'b0}}, |sh_full[EXT-1:0]};
    if (big_s == sm_s) begin
      r   = {1'b0, big_m} + {1'b0, al};
      r_s = big_s;
    end else if (big_m >= al) begin
      r   = {1'b0, big_m - al};
      r_s = big_s;
    end else begin
      r   = {1'b0, al - big_m};
      r_s = sm_s;
    end
    lz = lzc(r[EXT-1:0]);
    if (s1_zero) begin
      sum_nz = acc_nz; sum_s = acc_sign; sum_e = acc_exp; sum_m = acc_mag;
    end else if (r[EXT]) begin
      sum_nz = 1'b1;
      sum_s  = r_s;
      sum_e  = big_e + AEW'(1);
      sum_m  = {r[EXT:2], r[1] | r[0]};
    end else if (r[EXT-1:0] == '0) begin
      sum_nz = 1'b0; sum_s = 1'b0; sum_e = '0; sum_m = '0;
    end else begin
      sum_nz = 1'b1;
      sum_s  = r_s;
      sum_e  = big_e - $signed(AEW'(lz));
      sum_m  = r[EXT-1:0] << lz;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_nz   <= 1'b0;
      acc_sign <= 1'b0;
      acc_exp  <= '0;
      acc_mag  <= '0;
      acc_cnt  <= '0;
      s2_valid <= 1'b0;
      s2_nz    <= 1'b0;
      s2_sign  <= 1'b0;
      s2_exp   <= '0;
      s2_mag   <= '0;
      s2_taps  <= '0;
    end else if (adv) begin
      s2_valid <= s1_valid && s1_last;
      if (s1_valid) begin
        if (s1_last) begin
          s2_nz    <= sum_nz;
          s2_sign  <= sum_s;
          s2_exp   <= sum_e;
          s2_mag   <= sum_m;
          s2_taps  <= cnt_inc;
          acc_nz   <= 1'b0;
          acc_sign <= 1'b0;
          acc_exp  <= '0;
          acc_mag  <= '0;
          acc_cnt  <= '0;
        end else begin
          acc_nz   <= sum_nz;
          acc_sign <= sum_s;
          acc_exp  <= sum_e;
          acc_mag  <= sum_m;
          acc_cnt  <= cnt_inc;
        end
      end
    end
  end

  logic [MAN_W:0]      rm;
  logic                g_bit, r_bit, st_bit, rinc;
  logic [MAN_W+1:0]    rnd;
  logic [MAN_W-1:0]    frac_n;
  logic signed [AEW:0] bexp;
  logic [W-1:0]        y_n;
  logic                ovf_n, uf_n;

  assign rm     = s2_mag[EXT-1 -: MAN_W+1];
  assign g_bit  = s2_mag[EXT-2-MAN_W];
  assign r_bit  = s2_mag[EXT-3-MAN_W];
  assign st_bit = |s2_mag[EXT-4-MAN_W:0];
  assign rinc   = g_bit & (r_bit | st_bit | rm[0]);
  assign rnd    = {1'b0, rm} + (MAN_W+2)'(rinc);
  assign frac_n = rnd[MAN_W+1] ? rnd[MAN_W:1] : rnd[MAN_W-1:0];
  assign bexp   = (AEW+1)'(s2_exp) + (AEW+1)'(BIAS)
                + $signed({{AEW{1'b0}}, rnd[MAN_W+1]});

  always_comb begin
    y_n   = '0;
    ovf_n = 1'b0;
    uf_n  = 1'b0;
    if (!s2_nz) begin
      y_n = '0;
    end else if (bexp >= (AEW+1)'(EMAX)) begin
      y_n   = {s2_sign, EXP_W'(EMAX - 1), {MAN_W{1'b1}}};
      ovf_n = 1'b1;
    end else if (bexp <= (AEW+1)'(0)) begin
      y_n  = {s2_sign, {(EXP_W + MAN_W){1'b0}}};
      uf_n = 1'b1;
    end else begin
      y_n = {s2_sign, bexp[EXP_W-1:0], frac_n};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_y     <= '0;
      out_taps  <= '0;
      out_ovf   <= 1'b0;
      out_uf    <= 1'b0;
    end else if (adv) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_y    <= y_n;
        out_taps <= s2_taps;
        out_ovf  <= ovf_n;
        out_uf   <= uf_n;
      end
    end
  end

endmodule
